// File: rtl/if_pkg.sv
// Shared IF-stage definitions: fetch FSM states,
// well-known instruction words and the PC increment.
package if_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;
  localparam logic [31:0] INSTR_HALT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP    = 32'd4;

endpackage

// File: rtl/if_fetch_ctrl.sv
// IF fetch sequencer: owns the PC, drives the imem address and
// registers the returned word into the IF/ID slot (valid/ready).
// Ports: clk, reset (async high), start, imem_addr/imem_instr,
// if_valid/if_pc/if_instr with id_ready, redirect_valid/redirect_pc,
// halted, fetch_count.
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted,
  output logic [15:0] fetch_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         valid_q, valid_d;
  logic [31:0]  spc_q, spc_d;
  logic [31:0]  sins_q, sins_d;
  logic [15:0]  cnt_q, cnt_d;

  logic        hs;
  logic        slot_free;
  logic        halt_word;
  logic [31:0] tgt;

  assign hs        = valid_q & id_ready;
  assign slot_free = ~valid_q | id_ready;
  assign halt_word = HALT_ON_ZERO && (imem_instr == INSTR_HALT);
  assign tgt       = {redirect_pc[31:2], 2'b00};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    spc_d   = spc_q;
    sins_d  = sins_q;
    cnt_d   = hs ? cnt_q + 16'd1 : cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
        if (redirect_valid) pc_d = tgt;
        if (hs) valid_d = 1'b0;
      end
      S_FETCH: begin
        if (redirect_valid) begin
          // redirect flushes the slot even if ID is stalled
          pc_d    = tgt;
          valid_d = 1'b0;
        end else if (slot_free) begin
          if (halt_word) begin
            // slot_free implies any held word was consumed
            state_d = S_HALT;
            valid_d = 1'b0;
          end else begin
            spc_d   = pc_q;
            sins_d  = imem_instr;
            valid_d = 1'b1;
            pc_d    = pc_q + PC_STEP;
          end
        end else if (hs) begin
          valid_d = 1'b0;
        end
      end
      S_HALT: begin
        if (hs) valid_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      spc_q   <= 32'h0;
      sins_q  <= 32'h0;
      cnt_q   <= 16'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      spc_q   <= spc_d;
      sins_q  <= sins_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_valid    = valid_q;
  assign if_pc       = spc_q;
  assign if_instr    = sins_q;
  assign halted      = (state_q == S_HALT);
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed program scenarios plus
// randomized runs against a behavioural fetch model.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, id_ready, redirect_valid;
  logic [31:0] redirect_pc;

  logic [31:0] imem_addr, imem_instr, if_pc, if_instr;
  logic        if_valid, halted;
  logic [15:0] fetch_count;

  logic [31:0] imem_addr0, imem_instr0, if_pc0, if_instr0;
  logic        if_valid0, halted0;
  logic [15:0] fetch_count0;

  logic [31:0] mem [0:63];

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] LW   = 32'h0010A103;
  localparam logic [31:0] BEQ  = 32'h00208463;

  always #5 clk = ~clk;

  assign imem_instr  = mem[imem_addr[7:2]];
  assign imem_instr0 = mem[imem_addr0[7:2]];

  if_fetch_ctrl #(.RESET_PC(32'h0), .HALT_ON_ZERO(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .id_ready(id_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halted(halted),
    .fetch_count(fetch_count)
  );

  if_fetch_ctrl #(.RESET_PC(32'h0), .HALT_ON_ZERO(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start),
    .imem_addr(imem_addr0), .imem_instr(imem_instr0),
    .if_valid(if_valid0), .if_pc(if_pc0), .if_instr(if_instr0),
    .id_ready(id_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halted(halted0),
    .fetch_count(fetch_count0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_program();
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = LW;
    mem[1] = 32'h00112023;
    mem[2] = 32'h002081B3;
    mem[3] = 32'h402081B3;
    mem[4] = 32'h0020F1B3;
    mem[5] = 32'h0020E1B3;
    mem[6] = BEQ;
    mem[7] = 32'h00000013;
  endtask

  task automatic hard_reset();
    reset = 1'b1;
    start = 1'b0;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    #2;
    reset = 1'b0;
  endtask

  task automatic begin_fetch();
    hard_reset();
    start = 1'b1;
    id_ready = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    #1;
    checks++;
    if (imem_addr !== 32'h0 || if_valid !== 1'b0 || if_pc !== 32'h0 ||
        if_instr !== 32'h0 || halted !== 1'b0 || fetch_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_vals addr=%h v=%b pc=%h ins=%h h=%b cnt=%0d want all zero",
               imem_addr, if_valid, if_pc, if_instr, halted, fetch_count);
    end
    step();
    step();
    checks++;
    if (imem_addr !== 32'h0 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start addr=%h v=%b want 0 0", imem_addr, if_valid);
    end
    reset = 1'b0;
    step();
    checks++;
    if (imem_addr !== 32'h0 || if_valid !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold addr=%h v=%b h=%b want 0 0 0", imem_addr, if_valid, halted);
    end
  endtask

  task automatic test_program();
    load_program();
    begin_fetch();
    checks++;
    if (if_valid !== 1'b0 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL first_cycle v=%b addr=%h want 0 0", if_valid, imem_addr);
    end
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'(4 * (k - 1)) ||
          if_instr !== mem[k - 1] || fetch_count !== 16'(k - 1)) begin
        errors++;
        $display("FAIL seq_%0d v=%b pc=%h ins=%h cnt=%0d want 1 %h %h %0d",
                 k, if_valid, if_pc, if_instr, fetch_count,
                 32'(4 * (k - 1)), mem[k - 1], k - 1);
      end
    end
    checks++;
    if (if_instr0 !== 32'h0020E1B3 && if_pc0 === 32'h14) begin
      errors++;
      $display("FAIL nz_slot ins=%h want 0020e1b3", if_instr0);
    end
    step();
    checks++;
    if (halted !== 1'b1 || imem_addr !== 32'h20 ||
        fetch_count !== 16'd8 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt h=%b addr=%h cnt=%0d v=%b want 1 20 8 0",
               halted, imem_addr, fetch_count, if_valid);
    end
    checks++;
    if (if_valid0 !== 1'b1 || if_pc0 !== 32'h20 ||
        if_instr0 !== 32'h0 || halted0 !== 1'b0 || fetch_count0 !== 16'd8) begin
      errors++;
      $display("FAIL nohalt_param v=%b pc=%h ins=%h h=%b cnt=%0d want 1 20 0 0 8",
               if_valid0, if_pc0, if_instr0, halted0, fetch_count0);
    end
    step();
    step();
    checks++;
    if (halted !== 1'b1 || imem_addr !== 32'h20 || fetch_count !== 16'd8) begin
      errors++;
      $display("FAIL halt_hold h=%b addr=%h cnt=%0d want 1 20 8",
               halted, imem_addr, fetch_count);
    end
  endtask

  task automatic test_backpressure();
    load_program();
    begin_fetch();
    repeat (3) step();
    id_ready = 1'b0;
    repeat (3) step();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== mem[2] ||
        imem_addr !== 32'hC || fetch_count !== 16'd2) begin
      errors++;
      $display("FAIL stall v=%b pc=%h ins=%h addr=%h cnt=%0d want 1 8 %h c 2",
               if_valid, if_pc, if_instr, imem_addr, fetch_count, mem[2]);
    end
    id_ready = 1'b1;
    step();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'hC || fetch_count !== 16'd3) begin
      errors++;
      $display("FAIL resume v=%b pc=%h cnt=%0d want 1 c 3",
               if_valid, if_pc, fetch_count);
    end
  endtask

  task automatic test_redirect();
    load_program();
    begin_fetch();
    repeat (2) step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h1A;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (if_valid !== 1'b0 || imem_addr !== 32'h18 || fetch_count !== 16'd2) begin
      errors++;
      $display("FAIL redir_bubble v=%b addr=%h cnt=%0d want 0 18 2",
               if_valid, imem_addr, fetch_count);
    end
    step();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h18 || if_instr !== BEQ) begin
      errors++;
      $display("FAIL redir_target v=%b pc=%h ins=%h want 1 18 %h",
               if_valid, if_pc, if_instr, BEQ);
    end
  endtask

  task automatic test_redirect_beats_halt();
    load_program();
    begin_fetch();
    repeat (8) step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (halted !== 1'b0 || if_valid !== 1'b0 ||
        imem_addr !== 32'h10 || fetch_count !== 16'd8) begin
      errors++;
      $display("FAIL redir_halt h=%b v=%b addr=%h cnt=%0d want 0 0 10 8",
               halted, if_valid, imem_addr, fetch_count);
    end
    step();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h10) begin
      errors++;
      $display("FAIL redir_halt_next v=%b pc=%h want 1 10", if_valid, if_pc);
    end
  endtask

  task automatic test_ignored_inputs();
    load_program();
    begin_fetch();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h4 || halted !== 1'b0) begin
      errors++;
      $display("FAIL start_in_fetch v=%b pc=%h h=%b want 1 4 0",
               if_valid, if_pc, halted);
    end
    repeat (8) step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h4;
    start = 1'b1;
    step();
    step();
    redirect_valid = 1'b0;
    start = 1'b0;
    checks++;
    if (halted !== 1'b1 || imem_addr !== 32'h20 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_ignores h=%b addr=%h v=%b want 1 20 0",
               halted, imem_addr, if_valid);
    end
  endtask

  task automatic test_reset_midstream();
    load_program();
    begin_fetch();
    repeat (6) step();
    checks++;
    if (if_pc !== 32'h14) begin
      errors++;
      $display("FAIL pre_reset pc=%h want 14", if_pc);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (imem_addr !== 32'h0 || if_valid !== 1'b0 || if_pc !== 32'h0 ||
        if_instr !== 32'h0 || halted !== 1'b0 || fetch_count !== 16'h0) begin
      errors++;
      $display("FAIL async_reset addr=%h v=%b pc=%h ins=%h h=%b cnt=%0d want zeros",
               imem_addr, if_valid, if_pc, if_instr, halted, fetch_count);
    end
    reset = 1'b0;
    step();
    begin_fetch();
    step();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || fetch_count !== 16'h0) begin
      errors++;
      $display("FAIL restart v=%b pc=%h cnt=%0d want 1 0 0",
               if_valid, if_pc, fetch_count);
    end
  endtask

  // Behavioural model: fetching runs ahead of a one-entry slot.
  bit          m_started, m_stopped, m_full;
  logic [31:0] m_pc, m_spc, m_sins;
  logic [15:0] m_cnt;

  task automatic test_random();
    bit          n_started, n_stopped, n_full, took;
    logic [31:0] n_pc, n_spc, n_sins, word;
    logic [15:0] n_cnt;
    for (int run = 0; run < 8; run++) begin
      for (int i = 0; i < 64; i++)
        mem[i] = ($urandom_range(0, 15) == 0) ? 32'h0 : ($urandom | 32'h1);
      hard_reset();
      m_started = 0; m_stopped = 0; m_full = 0;
      m_pc = 0; m_spc = 0; m_sins = 0; m_cnt = 0;
      for (int c = 0; c < 150; c++) begin
        start = ($urandom_range(0, 3) == 0);
        id_ready = ($urandom_range(0, 9) < 7);
        redirect_valid = ($urandom_range(0, 7) == 0);
        redirect_pc = $urandom;
        word = mem[m_pc[7:2]];
        took = m_full && id_ready;
        n_started = m_started; n_stopped = m_stopped;
        n_full = m_full && !took;
        n_pc = m_pc; n_spc = m_spc; n_sins = m_sins;
        n_cnt = m_cnt + (took ? 16'd1 : 16'd0);
        if (!m_started && !m_stopped && start) n_started = 1;
        if (redirect_valid && !m_stopped) begin
          n_pc = redirect_pc & ~32'h3;
          if (m_started) n_full = 0;
        end else if (m_started && !n_full) begin
          if (word == 32'h0) begin
            n_stopped = 1;
            n_started = 0;
          end else begin
            n_full = 1;
            n_spc = m_pc;
            n_sins = word;
            n_pc = m_pc + 32'd4;
          end
        end
        step();
        m_started = n_started; m_stopped = n_stopped; m_full = n_full;
        m_pc = n_pc; m_spc = n_spc; m_sins = n_sins; m_cnt = n_cnt;
        checks++;
        if (imem_addr !== m_pc || if_valid !== m_full || if_pc !== m_spc ||
            if_instr !== m_sins || halted !== m_stopped || fetch_count !== m_cnt) begin
          errors++;
          $display("FAIL rand r%0d c%0d got a=%h v=%b p=%h i=%h h=%b n=%0d want a=%h v=%b p=%h i=%h h=%b n=%0d",
                   run, c, imem_addr, if_valid, if_pc, if_instr, halted, fetch_count,
                   m_pc, m_full, m_spc, m_sins, m_stopped, m_cnt);
        end
      end
    end
  endtask

  initial begin
    load_program();
    test_reset();
    test_program();
    test_backpressure();
    test_redirect();
    test_redirect_beats_halt();
    test_ignored_inputs();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
